// File: rtl/timer_arbiter_pkg.sv
// Shared types for the two-client timer arbiter.
// State encoding, client indices and a one-hot helper.
package timer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int C0 = 0;
    localparam int C1 = 1;

    function automatic logic [1:0] onehot(input logic idx);
        logic [1:0] v;
        v      = 2'b00;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/timer_arbiter_count.sv
// W-bit up-counter with async clear, sync zero and enable.
// Zero dominates enable.
module count_core #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         zero,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q <= '0;
        end else if (zero) begin
            q <= '0;
        end else if (en) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin owner of one shared interval counter.
// Each owner counts 0..tc, then gets a one-cycle done pulse.
import timer_arbiter_pkg::*;

module timer_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic [1:0]   req,
    input  logic [W-1:0] tc0,
    input  logic [W-1:0] tc1,
    input  logic         tick,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic [W-1:0] count,
    output logic         busy
);

    state_t         state, state_n;
    logic           owner, owner_n;
    logic           prio, prio_n;
    logic [W-1:0]   tc_q, tc_n;
    logic           zero;
    logic           en;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            owner <= 1'b0;
            prio  <= 1'b0;
            tc_q  <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            prio  <= prio_n;
            tc_q  <= tc_n;
        end
    end

    // Abort outranks the terminal match in COUNT.
    always_comb begin
        state_n = state;
        owner_n = owner;
        prio_n  = prio;
        tc_n    = tc_q;
        zero    = 1'b1;
        en      = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_n = COUNT;
                    owner_n = (req == 2'b11) ? prio : req[C1];
                    tc_n    = owner_n ? tc1 : tc0;
                end
            end
            COUNT: begin
                if (!req[owner]) begin
                    state_n = IDLE;
                    prio_n  = ~owner;
                end else if (count == tc_q) begin
                    state_n = DONE;
                    zero    = 1'b0;
                end else begin
                    zero    = 1'b0;
                    en      = tick;
                end
            end
            DONE: begin
                state_n = IDLE;
                prio_n  = ~owner;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    count_core #(
        .W(W)
    ) u_count (
        .clk   (clk),
        .clear (clear),
        .zero  (zero),
        .en    (en),
        .q     (count)
    );

    assign busy = (state == COUNT) || (state == DONE);
    assign gnt  = busy ? onehot(owner) : 2'b00;
    assign done = (state == DONE) ? onehot(owner) : 2'b00;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter.
// Inputs change 1 time unit after each rising edge; outputs sampled there too.
module tb_timer_arbiter;

    logic       clk;
    logic       clear;
    logic [1:0] req;
    logic [3:0] tc0;
    logic [3:0] tc1;
    logic       tick;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [3:0] count;
    logic       busy;

    int checks;
    int failures;

    timer_arbiter #(
        .W(4)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .req   (req),
        .tc0   (tc0),
        .tc1   (tc1),
        .tick  (tick),
        .gnt   (gnt),
        .done  (done),
        .count (count),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] g,
                              input logic [1:0] d, input logic [3:0] c,
                              input logic b);
        check({tag, ".gnt"},   32'(gnt),   32'(g));
        check({tag, ".done"},  32'(done),  32'(d));
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".busy"},  32'(busy),  32'(b));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        clear = 1'b0;
        #2;
        expect_out("rst", 2'b00, 2'b00, 4'd0, 1'b0);
        clear = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear    = 1'b0;
        req      = 2'b01;
        tc0      = 4'd3;
        tc1      = 4'd0;
        tick     = 1'b1;
        #1;

        // T1: single client, tc0=3
        reset_dut();
        step();
        expect_out("t1.grant", 2'b01, 2'b00, 4'd0, 1'b1);
        tc0 = 4'd9;
        for (int k = 1; k <= 3; k++) begin
            step();
            expect_out($sformatf("t1.cnt%0d", k), 2'b01, 2'b00, 4'(k), 1'b1);
        end
        step();
        expect_out("t1.done", 2'b01, 2'b01, 4'd3, 1'b1);
        req = 2'b00;
        step();
        expect_out("t1.idle", 2'b00, 2'b00, 4'd0, 1'b0);

        // T2: both request, round robin
        reset_dut();
        req = 2'b11; tc0 = 4'd2; tc1 = 4'd1; tick = 1'b1;
        step();
        expect_out("t2.g0", 2'b01, 2'b00, 4'd0, 1'b1);
        step();
        step();
        expect_out("t2.c2", 2'b01, 2'b00, 4'd2, 1'b1);
        step();
        expect_out("t2.d0", 2'b01, 2'b01, 4'd2, 1'b1);
        step();
        expect_out("t2.idle", 2'b00, 2'b00, 4'd0, 1'b0);
        step();
        expect_out("t2.g1", 2'b10, 2'b00, 4'd0, 1'b1);
        req = 2'b10;
        step();
        expect_out("t2.c1", 2'b10, 2'b00, 4'd1, 1'b1);
        step();
        expect_out("t2.d1", 2'b10, 2'b10, 4'd1, 1'b1);
        req = 2'b00;
        step();
        expect_out("t2.idle2", 2'b00, 2'b00, 4'd0, 1'b0);
        req = 2'b11;
        step();
        check("t2.prio0", 32'(gnt), 32'(2'b01));
        req = 2'b00;
        step();

        // T3: tick toggling, tc0=5
        reset_dut();
        req = 2'b01; tc0 = 4'd5; tick = 1'b0;
        step();
        expect_out("t3.grant", 2'b01, 2'b00, 4'd0, 1'b1);
        for (int k = 2; k <= 10; k++) begin
            tick = (k % 2 == 0);
            step();
            check($sformatf("t3.cnt_e%0d", k), 32'(count), 32'(k / 2));
            check($sformatf("t3.nodone_e%0d", k), 32'(done), 32'(2'b00));
        end
        tick = 1'b0;
        step();
        expect_out("t3.done", 2'b01, 2'b01, 4'd5, 1'b1);
        req = 2'b00;
        step();
        expect_out("t3.idle", 2'b00, 2'b00, 4'd0, 1'b0);

        // T4: abort at count=2 with req1 pending
        reset_dut();
        req = 2'b11; tc0 = 4'd6; tc1 = 4'd2; tick = 1'b1;
        step();
        expect_out("t4.g0", 2'b01, 2'b00, 4'd0, 1'b1);
        step();
        step();
        expect_out("t4.c2", 2'b01, 2'b00, 4'd2, 1'b1);
        req = 2'b10;
        step();
        expect_out("t4.abort", 2'b00, 2'b00, 4'd0, 1'b0);
        step();
        expect_out("t4.g1", 2'b10, 2'b00, 4'd0, 1'b1);
        req = 2'b00;
        step();

        // T5: tc0=0 then tc1=15
        reset_dut();
        req = 2'b01; tc0 = 4'd0; tc1 = 4'd15; tick = 1'b1;
        step();
        expect_out("t5.g0", 2'b01, 2'b00, 4'd0, 1'b1);
        step();
        expect_out("t5.d0", 2'b01, 2'b01, 4'd0, 1'b1);
        req = 2'b10;
        step();
        expect_out("t5.idle", 2'b00, 2'b00, 4'd0, 1'b0);
        step();
        expect_out("t5.g1", 2'b10, 2'b00, 4'd0, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            step();
            check($sformatf("t5.cnt%0d", k), 32'(count), 32'(k));
        end
        step();
        expect_out("t5.d1", 2'b10, 2'b10, 4'd15, 1'b1);
        req = 2'b00;
        step();
        expect_out("t5.idle2", 2'b00, 2'b00, 4'd0, 1'b0);

        // T6: async clear mid-count
        reset_dut();
        req = 2'b01; tc0 = 4'd9; tick = 1'b1;
        for (int k = 0; k <= 4; k++) step();
        expect_out("t6.c4", 2'b01, 2'b00, 4'd4, 1'b1);
        #2;
        clear = 1'b0;
        #1;
        expect_out("t6.async", 2'b00, 2'b00, 4'd0, 1'b0);
        #1;
        clear = 1'b1;
        req   = 2'b11;
        step();
        expect_out("t6.g0", 2'b01, 2'b00, 4'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one W-bit up-counter between two requesters. Each requester asks for a timed interval of tc ticks.
- A round-robin arbiter grants the counter to one requester at a time. The counter runs from 0 to that requester's terminal value, then the block returns a one-cycle done pulse to the owner.
- Sits between the counter datapath and client logic that needs event or delay counting.

Parameters:
W, 4, counter and terminal-value width in bits.

Ports:
clk  input  1  rising-edge system clock
clear  input  1  asynchronous active-low reset; 0 forces reset state immediately
req  input  2  request per client; held high until done (or dropped to abort)
tc0  input  W  terminal count for client 0; sampled at grant edge
tc1  input  W  terminal count for client 1; sampled at grant edge
tick  input  1  count enable; counter advances only on edges where tick=1
gnt  output  2  one-hot grant; 00 when idle
done  output  2  one-hot, one-cycle completion pulse to owner
count  output  W  current counter value
busy  output  1  high in COUNT and DONE states

Behaviour:
- Reset (clear=0, async): state=IDLE, gnt=00, done=00, count=0, busy=0, prio=0 (client 0 favoured). Release is synchronous to next clk edge; logic acts from first edge with clear=1.
- State IDLE:
  - req=00: stay.
  - One bit set: grant it.
  - req=11: grant client prio.
  - On the grant edge: state->COUNT, gnt=one-hot owner, count=0, busy=1, tc_q<=tc of owner. Later tc changes are ignored.
- State COUNT, evaluated each edge in priority order:
  - (1) req[owner]=0 -> abort: state->IDLE, gnt=00, count=0, busy=0, no done, prio<=other client.
  - (2) count==tc_q -> state->DONE, done[owner]=1, count holds.
  - (3) tick=1 -> count+1.
  - (4) else hold.
- State DONE, lasts exactly one cycle: gnt still set, done[owner]=1. Next edge: state->IDLE, gnt=00, done=00, count=0, busy=0, prio<=other client.
- Latency: with tick held at 1 and grant edge g, count=k after edge g+k. done is high in the cycle after edge g+tc_q+1, and gnt drops at edge g+tc_q+2.
- tc_q=0: DONE on the edge after grant; no counting.
- tc_q=2^W-1: counts to all-ones. No wrap is possible, since count never exceeds tc_q.
- Abort takes precedence over terminal match on the same edge.
- A requester still high in IDLE after its done is a fresh request. Because prio has flipped, a waiting other client wins.
- A non-owner request during COUNT/DONE is held pending. No preemption.
- gnt and done are never both non-zero for different clients. done is never set without gnt.
- An async reset mid-COUNT discards the interval with no done pulse.

Decomposition:
- Shared package: state encoding constants IDLE=2'b00, COUNT=2'b01, DONE=2'b10, and client index constants C0=0, C1=1.
- One sub-module, count_core: W-bit counter with async active-low clear, synchronous zero, and enable. Ports clk, clear, zero, en, q.
- FSM, arbiter and tc_q register stay in timer_arbiter.

Test Plan:
- Reset with req=01, tc0=3, tick=1 held after clear rises -> gnt=01 after first edge; count 1,2,3; done=01 for one cycle after edge 5; gnt=00, busy=0 after edge 6.
- req=11 from reset, tc0=2, tc1=1, clients drop req the cycle after their done -> client 0 served first; then gnt=10 on the following grant edge; done=10 after client 1 completes; prio ends at 0.
- Client 0 granted with tc0=5, tick toggling 1/0 -> count advances only on tick=1 edges; done after 5 tick-high edges plus one match edge.
- req0 dropped when count=2 (tc0=6) -> gnt=00, count=0 next edge; no done pulse; pending req1 granted on the following edge.
- tc0=0 -> done=01 one edge after grant, count stays 0; then tc1=15 with W=4 -> count reaches 15, done=10, no wrap.
- clear pulsed low mid-COUNT (count=4) -> gnt, done, count and busy go 0 immediately without a clock; after release, req0 and req1 both high -> client 0 granted (prio reset).
